ex_mem_pipe_stage: RTL and testbench
====================================

Name: ex_mem_pipe_stage

Overview:
- Parametrised successor to the EX→MEM pipeline buffer.
- Registers the ALU result, the store data, the destination register index and the RAM/BR enables between EX and MEM.
- Adds a valid/ready handshake with a 2-entry skid, stall-safe enables, a flush, and RAM address extraction.
- Sits between the ALU/forwarding mux and the data RAM / register-bank write-back path.

Parameters:
- DATA_W, 32, width of ALU result, store data and write-back data.
- REG_AW, 5, width of destination register index wA.
- RAM_AW, 8, width of the RAM address taken from the ALU result.
- SKID_EN, 1, 1 = 2-entry skid (registered o_ready); 0 = single entry with o_ready = !o_valid | i_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_flush  in  1  kill all held entries (branch/exception squash).
- i_valid  in  1  EX presents a valid instruction.
- o_ready  out  1  stage can accept this cycle.
- i_uc_e_read_ram  in  1  load enable from control unit.
- i_uc_e_write_ram  in  1  store enable.
- i_uc_e_write_br  in  1  register-bank write enable.
- i_wA  in  REG_AW  destination register.
- i_alu_result  in  DATA_W  ALU result / effective address.
- i_DR2  in  DATA_W  store data.
- o_valid  out  1  MEM-side entry valid.
- i_ready  in  1  MEM accepts this cycle.
- o_uc_e_read_ram  out  1  gated load enable.
- o_uc_e_write_ram  out  1  gated store enable.
- o_uc_e_write_br  out  1  gated BR write enable.
- o_wA  out  REG_AW  destination register.
- o_address_ram  out  RAM_AW  equals alu_result[RAM_AW-1:0].
- o_dW  out  DATA_W  write-back data (ALU result).
- o_din_ram  out  DATA_W  RAM write data.

Behaviour:
- Handshakes:
  - Accept when i_valid & o_ready.
  - Retire when o_valid & i_ready.
  - Payload = {enables, wA, alu_result, DR2}.
- Occupancy states (SKID_EN=1): EMPTY, ONE (main full), TWO (main + skid full).
  - EMPTY: on accept → ONE.
  - ONE, accept & retire: main ← new, stay ONE.
  - ONE, accept only: skid ← new, → TWO.
  - ONE, retire only: → EMPTY.
  - TWO: o_ready = 0. On retire, main ← skid, → ONE.
  - o_ready = (state != TWO). It is a registered decode, with no combinational path from i_ready.
- SKID_EN=0:
  - Single entry.
  - Loads when accepted.
  - o_ready = !o_valid | i_ready (combinational).
- Latency and ordering:
  - Accepted payload appears on outputs the cycle after accept when the stage was EMPTY (or ONE with simultaneous retire).
  - Order is strictly FIFO.
- Output holding: while o_valid & !i_ready, all outputs are stable.
- Enable gating:
  - o_uc_e_read_ram, o_uc_e_write_ram and o_uc_e_write_br = stored bit & o_valid.
  - A bubble or stall never issues a RAM write or BR write.
  - Data outputs may hold stale values when o_valid = 0.
- Flush:
  - i_flush = 1 → next cycle state EMPTY, o_valid = 0, o_ready = 1.
  - Flush has priority over a simultaneous accept; that input is dropped.
  - Flush has priority over a simultaneous retire; the retire still completes downstream this cycle, since outputs were valid.
- Reset:
  - rst = 1 → every output register is 0 next edge (o_valid, enables, wA, address, dW, din_ram), state EMPTY.
  - o_ready = 1 after the reset edge, and also while rst is held.
  - Reset has priority over flush and handshakes, including mid-stall with TWO entries.
- Width rules:
  - RAM_AW ≤ DATA_W (elaboration check).
  - The address is a plain truncation, with no scaling.

Decomposition:
- Shared package pipe_pkg holds:
  - occupancy enum (EMPTY, ONE, TWO);
  - DATA_W, REG_AW and RAM_AW defaults;
  - the payload bundle width constant.
- Natural sub-module: pipe_skid_slot, a generic DATA-wide register slot with load/hold. It is instanced twice (main, skid); the parent owns the FSM.

Test Plan:
- Reset:
  - Stimulus: drive all inputs 1s and hold rst for 2 cycles.
  - Response: all outputs 0 and o_ready = 1 after the first edge.
- Streaming:
  - Stimulus: i_ready = 1; push alu_result = 0x0000_0010, 0x0000_0020, 0x0000_0030 on consecutive cycles with write_br = 1, wA = 3, 4, 5.
  - Response: o_dW follows one cycle later in order; o_address_ram = 0x10, 0x20, 0x30.
- Backpressure:
  - Stimulus: i_ready = 0; push 3 items A, B, C.
  - Response: A and B accepted, o_ready = 0 on the third cycle, C held upstream, outputs stable on A.
  - Then raise i_ready: A, B, C retire in order, with no loss or duplication.
- Enable gating:
  - Stimulus: store with DR2 = 0xDEAD_BEEF, followed by i_valid = 0 for 3 cycles with i_ready = 1.
  - Response: o_uc_e_write_ram high exactly 1 cycle, o_din_ram = 0xDEAD_BEEF during it.
- Flush:
  - Stimulus: in state TWO, assert i_flush together with i_valid.
  - Response: next cycle o_valid = 0, o_ready = 1, no enable asserted, and the flushed/new items never appear.
- SKID_EN=0 build:
  - Stimulus: rerun the backpressure test.
  - Response: o_ready tracks !o_valid | i_ready combinationally, and ordering is preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the EX->MEM pipeline stage.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int RAM_AW_DEF = 8;
  localparam int N_EN       = 3;

  // Payload = {read_ram, write_ram, write_br, wA, alu_result, DR2}
  function automatic int payload_w(input int dw, input int aw);
    return N_EN + aw + 2 * dw;
  endfunction

  localparam int PAYLOAD_W = payload_w(DATA_W_DEF, REG_AW_DEF);
endpackage

// File: rtl/pipe_skid_slot.sv
// Generic register slot with synchronous clear and load/hold.
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline buffer with valid/ready handshake, optional 2-entry skid and flush.
module ex_mem_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int RAM_AW  = RAM_AW_DEF,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_uc_e_read_ram,
  input  logic              i_uc_e_write_ram,
  input  logic              i_uc_e_write_br,
  input  logic [REG_AW-1:0] i_wA,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_DR2,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_uc_e_read_ram,
  output logic              o_uc_e_write_ram,
  output logic              o_uc_e_write_br,
  output logic [REG_AW-1:0] o_wA,
  output logic [RAM_AW-1:0] o_address_ram,
  output logic [DATA_W-1:0] o_dW,
  output logic [DATA_W-1:0] o_din_ram
);
  localparam int PW = payload_w(DATA_W, REG_AW);

  if (RAM_AW > DATA_W) begin : g_width_check
    $error("RAM_AW must not exceed DATA_W");
  end

  occ_e            state;
  logic            accept, retire, main_load, skid_load;
  logic [PW-1:0]   pay_in, main_d, main_q, skid_q;
  logic [2:0]      en_q;

  assign pay_in = {i_uc_e_read_ram, i_uc_e_write_ram, i_uc_e_write_br, i_wA, i_alu_result, i_DR2};
  assign o_valid = (state != EMPTY);

  // Skid build: ready depends only on state (and rst), never on i_ready.
  if (SKID_EN) begin : g_rdy_skid
    assign o_ready = rst | (state != TWO);
  end else begin : g_rdy_flat
    assign o_ready = rst | ~o_valid | i_ready;
  end

  always_comb begin
    accept    = i_valid & o_ready;
    retire    = o_valid & i_ready;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = pay_in;
    if (!i_flush) begin
      case (state)
        EMPTY:   main_load = accept;
        ONE: begin
          main_load = accept & retire;
          skid_load = SKID_EN & accept & ~retire;
        end
        TWO: begin
          main_load = retire;
          main_d    = skid_q;
        end
        default: main_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) state <= EMPTY;
    else begin
      case (state)
        EMPTY:   if (accept) state <= ONE;
        ONE: begin
          if (accept && !retire)      state <= TWO;
          else if (!accept && retire) state <= EMPTY;
        end
        TWO:     if (retire) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_skid_slot #(.W(PW)) u_main (.clk(clk), .rst(rst), .load(main_load), .d(main_d), .q(main_q));
  pipe_skid_slot #(.W(PW)) u_skid (.clk(clk), .rst(rst), .load(skid_load), .d(pay_in), .q(skid_q));

  assign {en_q, o_wA, o_dW, o_din_ram} = main_q;
  assign o_address_ram    = o_dW[RAM_AW-1:0];
  // Enables are masked so a bubble can never write RAM or the register bank.
  assign o_uc_e_read_ram  = en_q[2] & o_valid;
  assign o_uc_e_write_ram = en_q[1] & o_valid;
  assign o_uc_e_write_br  = en_q[0] & o_valid;
endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed vector bench for ex_mem_pipe_stage, skid and single-entry builds.
module tb_ex_mem_pipe_stage;
  logic        clk = 1'b0;
  logic        rst, flush, iv, ir, rd, wr, br;
  logic [4:0]  wa;
  logic [31:0] alu, dr2;

  logic        s_rdy, s_vld, s_rd, s_wr, s_br;
  logic [4:0]  s_wa;
  logic [7:0]  s_addr;
  logic [31:0] s_dw, s_din;
  logic        f_rdy, f_vld, f_rd, f_wr, f_br;
  logic [4:0]  f_wa;
  logic [7:0]  f_addr;
  logic [31:0] f_dw, f_din;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_stage #(.SKID_EN(1'b1)) u_skid (
    .clk(clk), .rst(rst), .i_flush(flush), .i_valid(iv), .o_ready(s_rdy),
    .i_uc_e_read_ram(rd), .i_uc_e_write_ram(wr), .i_uc_e_write_br(br),
    .i_wA(wa), .i_alu_result(alu), .i_DR2(dr2), .o_valid(s_vld), .i_ready(ir),
    .o_uc_e_read_ram(s_rd), .o_uc_e_write_ram(s_wr), .o_uc_e_write_br(s_br),
    .o_wA(s_wa), .o_address_ram(s_addr), .o_dW(s_dw), .o_din_ram(s_din));

  ex_mem_pipe_stage #(.SKID_EN(1'b0)) u_flat (
    .clk(clk), .rst(rst), .i_flush(flush), .i_valid(iv), .o_ready(f_rdy),
    .i_uc_e_read_ram(rd), .i_uc_e_write_ram(wr), .i_uc_e_write_br(br),
    .i_wA(wa), .i_alu_result(alu), .i_DR2(dr2), .o_valid(f_vld), .i_ready(ir),
    .o_uc_e_read_ram(f_rd), .o_uc_e_write_ram(f_wr), .o_uc_e_write_br(f_br),
    .o_wA(f_wa), .o_address_ram(f_addr), .o_dW(f_dw), .o_din_ram(f_din));

  // ctl = {rst, flush, valid, ready, rd, wr, br}; e_ctl = {ready, valid, rd, wr, br}
  typedef struct {
    logic [6:0]  ctl;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [31:0] dr2;
    logic [4:0]  e_ctl;
    logic [4:0]  e_wa;
    logic [7:0]  e_addr;
    logic [31:0] e_dw;
    logic [31:0] e_din;
  } vec_t;

  vec_t tbl[26];

  function automatic logic [81:0] exp_of(input vec_t v);
    return {v.e_ctl, v.e_wa, v.e_addr, v.e_dw, v.e_din};
  endfunction

  task automatic apply(input vec_t v);
    {rst, flush, iv, ir, rd, wr, br} = v.ctl;
    wa = v.wa; alu = v.alu; dr2 = v.dr2;
  endtask

  task automatic chk(input string nm, input logic [81:0] act, input logic [81:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Single-entry build: check combinational ready before the edge, then registered outputs after.
  task automatic flat_step(input string nm, input vec_t v, input logic pre_rdy);
    apply(v);
    #1;
    chk({nm, "_rdy"}, {81'd0, f_rdy}, {81'd0, pre_rdy});
    @(posedge clk); @(negedge clk);
    chk(nm, {f_rdy, f_vld, f_rd, f_wr, f_br, f_wa, f_addr, f_dw, f_din}, exp_of(v));
  endtask

  initial begin
    tbl[0]  = '{7'b1111111, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 5'd0, 8'h00, 32'h0, 32'h0};
    tbl[1]  = '{7'b1111111, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 5'd0, 8'h00, 32'h0, 32'h0};
    tbl[2]  = '{7'b0011001, 5'd3,  32'h10,  32'h0, 5'b11001, 5'd3, 8'h10, 32'h10, 32'h0};
    tbl[3]  = '{7'b0011001, 5'd4,  32'h20,  32'h0, 5'b11001, 5'd4, 8'h20, 32'h20, 32'h0};
    tbl[4]  = '{7'b0011001, 5'd5,  32'h30,  32'h0, 5'b11001, 5'd5, 8'h30, 32'h30, 32'h0};
    tbl[5]  = '{7'b0001000, 5'd0,  32'h0,   32'h0, 5'b10000, 5'd5, 8'h30, 32'h30, 32'h0};
    tbl[6]  = '{7'b0010100, 5'd6,  32'h100, 32'hA, 5'b11100, 5'd6, 8'h00, 32'h100, 32'hA};
    tbl[7]  = '{7'b0010100, 5'd7,  32'h204, 32'hB, 5'b01100, 5'd6, 8'h00, 32'h100, 32'hA};
    tbl[8]  = '{7'b0010100, 5'd8,  32'h3FF, 32'hC, 5'b01100, 5'd6, 8'h00, 32'h100, 32'hA};
    tbl[9]  = '{7'b0011100, 5'd8,  32'h3FF, 32'hC, 5'b11100, 5'd7, 8'h04, 32'h204, 32'hB};
    tbl[10] = '{7'b0011100, 5'd8,  32'h3FF, 32'hC, 5'b11100, 5'd8, 8'hFF, 32'h3FF, 32'hC};
    tbl[11] = '{7'b0001000, 5'd0,  32'h0,   32'h0, 5'b10000, 5'd8, 8'hFF, 32'h3FF, 32'hC};
    tbl[12] = '{7'b0011010, 5'd0,  32'h44,  32'hDEAD_BEEF, 5'b11010, 5'd0, 8'h44, 32'h44, 32'hDEAD_BEEF};
    tbl[13] = '{7'b0001000, 5'd0,  32'h0,   32'h0, 5'b10000, 5'd0, 8'h44, 32'h44, 32'hDEAD_BEEF};
    tbl[14] = '{7'b0001000, 5'd0,  32'h0,   32'h0, 5'b10000, 5'd0, 8'h44, 32'h44, 32'hDEAD_BEEF};
    tbl[15] = '{7'b0001000, 5'd0,  32'h0,   32'h0, 5'b10000, 5'd0, 8'h44, 32'h44, 32'hDEAD_BEEF};
    tbl[16] = '{7'b0010001, 5'd9,  32'h55,  32'h1, 5'b11001, 5'd9, 8'h55, 32'h55, 32'h1};
    tbl[17] = '{7'b0010001, 5'd10, 32'h66,  32'h2, 5'b01001, 5'd9, 8'h55, 32'h55, 32'h1};
    tbl[18] = '{7'b0110001, 5'd11, 32'h77,  32'h3, 5'b10000, 5'd9, 8'h55, 32'h55, 32'h1};
    tbl[19] = '{7'b0001000, 5'd0,  32'h0,   32'h0, 5'b10000, 5'd9, 8'h55, 32'h55, 32'h1};
    tbl[20] = '{7'b0011001, 5'd12, 32'h88,  32'h4, 5'b11001, 5'd12, 8'h88, 32'h88, 32'h4};
    tbl[21] = '{7'b0001000, 5'd0,  32'h0,   32'h0, 5'b10000, 5'd12, 8'h88, 32'h88, 32'h4};
    tbl[22] = '{7'b0010100, 5'd1,  32'h11,  32'h5, 5'b11100, 5'd1, 8'h11, 32'h11, 32'h5};
    tbl[23] = '{7'b0010100, 5'd2,  32'h22,  32'h6, 5'b01100, 5'd1, 8'h11, 32'h11, 32'h5};
    tbl[24] = '{7'b1010100, 5'd2,  32'h22,  32'h6, 5'b10000, 5'd0, 8'h00, 32'h0, 32'h0};
    tbl[25] = '{7'b0000000, 5'd0,  32'h0,   32'h0, 5'b10000, 5'd0, 8'h00, 32'h0, 32'h0};

    apply(tbl[0]);
    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      apply(tbl[i]);
      @(posedge clk); @(negedge clk);
      chk($sformatf("skid_vec%0d", i),
          {s_rdy, s_vld, s_rd, s_wr, s_br, s_wa, s_addr, s_dw, s_din}, exp_of(tbl[i]));
    end

    // Single-entry build: reset, then backpressure A, B, C in order.
    apply('{7'b1000000, 5'd0, 32'h0, 32'h0, 5'b0, 5'd0, 8'h0, 32'h0, 32'h0});
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("flat_reset", {f_rdy, f_vld, f_rd, f_wr, f_br, f_wa, f_addr, f_dw, f_din}, {5'b10000, 77'd0});
    flat_step("flat_A",    '{7'b0010100, 5'd6, 32'h100, 32'hA, 5'b01100, 5'd6, 8'h00, 32'h100, 32'hA}, 1'b1);
    flat_step("flat_hold", '{7'b0010100, 5'd7, 32'h204, 32'hB, 5'b01100, 5'd6, 8'h00, 32'h100, 32'hA}, 1'b0);
    flat_step("flat_B",    '{7'b0011100, 5'd7, 32'h204, 32'hB, 5'b11100, 5'd7, 8'h04, 32'h204, 32'hB}, 1'b1);
    flat_step("flat_C",    '{7'b0011100, 5'd8, 32'h3FF, 32'hC, 5'b11100, 5'd8, 8'hFF, 32'h3FF, 32'hC}, 1'b1);
    flat_step("flat_idle", '{7'b0001000, 5'd0, 32'h0,   32'h0, 5'b10000, 5'd8, 8'hFF, 32'h3FF, 32'hC}, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
